// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the iterative ALU shifter.
// Op codes, FSM state encoding and datapath widths.
package alu_shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_stage_mux.sv
// One barrel stage: shifts the accumulator by 2^k when enabled.
// Right shifts fill with i_fill; left shifts always fill with zero.
module shift_stage_mux
    import alu_shift_pkg::*;
(
    input  logic [WIDTH-1:0] i_acc,
    input  logic [2:0]       i_k,
    input  logic             i_dir,
    input  logic             i_fill,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_acc
);

    // Select the 2^k shifted value, or pass the accumulator through.
    always_comb begin
        o_acc = i_acc;
        if (i_en) begin
            unique case (i_k)
                3'd4: o_acc = i_dir ? {{16{i_fill}}, i_acc[31:16]}
                                    : {i_acc[15:0], 16'b0};
                3'd3: o_acc = i_dir ? {{8{i_fill}}, i_acc[31:8]}
                                    : {i_acc[23:0], 8'b0};
                3'd2: o_acc = i_dir ? {{4{i_fill}}, i_acc[31:4]}
                                    : {i_acc[27:0], 4'b0};
                3'd1: o_acc = i_dir ? {{2{i_fill}}, i_acc[31:2]}
                                    : {i_acc[29:0], 2'b0};
                3'd0: o_acc = i_dir ? {i_fill, i_acc[31:1]}
                                    : {i_acc[30:0], 1'b0};
                default: o_acc = i_acc;
            endcase
        end
    end

endmodule

// File: rtl/iterative_shift_unit.sv
// Registered multi-cycle shifter: one barrel stage per clock (16,8,4,2,1).
// Valid/ready on both sides; result held in DONE until consumed.
module iterative_shift_unit
    import alu_shift_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
)
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    state_e               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_out;
    logic [SHAMT_W-1:0]   r_shamt;
    logic                 r_dir;
    logic                 r_arith;
    logic [2:0]           r_k;

    logic [WIDTH-1:0]     w_stage;
    logic                 w_en;
    logic                 w_fill;
    logic [SHAMT_W-1:0]   w_mask;
    logic                 w_low_zero;
    logic                 w_last;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out;

    assign w_en       = r_shamt[r_k];
    assign w_fill     = r_arith & r_acc[WIDTH-1];
    assign w_mask     = (SHAMT_W'(1) << r_k) - SHAMT_W'(1);
    assign w_low_zero = ((r_shamt & w_mask) == '0);
    assign w_last     = (r_k == 3'd0) || (EARLY_EXIT && w_low_zero);

    shift_stage_mux u_stage (
        .i_acc  (r_acc),
        .i_k    (r_k),
        .i_dir  (r_dir),
        .i_fill (w_fill),
        .i_en   (w_en),
        .o_acc  (w_stage)
    );

    // Control FSM plus operand/accumulator/result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_out   <= '0;
            r_shamt <= '0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
            r_k     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc   <= in_data;
                        r_shamt <= in_shamt;
                        r_dir   <= in_op[0];
                        r_arith <= in_op[1] & in_op[0];
                        r_k     <= 3'd4;
                        if (EARLY_EXIT && (in_shamt == '0)) begin
                            r_out   <= in_data;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_stage;
                    if (w_last) begin
                        r_out   <= w_stage;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k - 3'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed + randomized bench for iterative_shift_unit.
// DUT 0 has EARLY_EXIT=0, DUT 1 has EARLY_EXIT=1; shared clock/reset.
module tb_iterative_shift_unit;

    logic        clk;
    logic        reset_n;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  busy;
    logic [31:0] in_data  [2];
    logic [4:0]  in_shamt [2];
    logic [1:0]  in_op    [2];
    logic [31:0] out_data [2];

    logic [31:0] exp_q [$];
    int n_cmp;
    int n_err;

    iterative_shift_unit #(.EARLY_EXIT(1'b0)) u_dut0 (
        .clock     (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .in_shamt  (in_shamt[0]),
        .in_op     (in_op[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .busy      (busy[0])
    );

    iterative_shift_unit #(.EARLY_EXIT(1'b1)) u_dut1 (
        .clock     (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .in_shamt  (in_shamt[1]),
        .in_op     (in_op[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .busy      (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                              input logic [4:0] s,
                                              input logic [1:0] op);
        if (!op[0]) return d << s;
        if (op[1]) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    function automatic int ref_lat(input int ee, input logic [4:0] s);
        if (ee == 0) return 6;
        if (s == 5'd0) return 1;
        for (int i = 0; i < 5; i++) if (s[i]) return 6 - i;
        return 6;
    endfunction

    task automatic drive(input int idx, input logic [31:0] d,
                         input logic [4:0] s, input logic [1:0] op,
                         input logic [31:0] exp);
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        in_shamt[idx] = s;
        in_op[idx]    = op;
        exp_q.push_back(exp);
    endtask

    // Called at the negedge before the accepting posedge.
    task automatic wait_result(input int idx, input int lat,
                               input string tag);
        int n;
        logic [31:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_busy"}, 32'(busy[idx]), 32'd1);
                in_valid[idx] = 1'b0;
                in_data[idx]  = $urandom;
                in_shamt[idx] = 5'($urandom);
                in_op[idx]    = 2'($urandom);
            end
        end while (out_valid[idx] !== 1'b1 && n < 40);
        e = 32'hxxxx_xxxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_data"}, out_data[idx], e);
    endtask

    task automatic run_op(input int idx, input logic [31:0] d,
                          input logic [4:0] s, input logic [1:0] op,
                          input logic [31:0] exp, input int lat,
                          input string tag);
        chk({tag, "_rdy"}, 32'(in_ready[idx]), 32'd1);
        drive(idx, d, s, op, exp);
        wait_result(idx, lat, tag);
        @(negedge clk);
        chk({tag, "_vdrop"}, 32'(out_valid[idx]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  rs;
        logic [1:0]  ro;
        n_cmp = 0;
        n_err = 0;
        reset_n   = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            in_data[i]  = '0;
            in_shamt[i] = '0;
            in_op[i]    = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(in_ready[i]), 32'd1);
            chk("rst_valid", 32'(out_valid[i]), 32'd0);
            chk("rst_data", out_data[i], 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        run_op(0, 32'h8000_0000, 5'd16, 2'b01, 32'h0000_8000, 6, "srl16");
        run_op(0, 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 6, "sra31n");
        run_op(0, 32'h7FFF_FFFF, 5'd31, 2'b11, 32'h0000_0000, 6, "sra31p");
        run_op(0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 6, "sll31");
        run_op(0, 32'h0000_000F, 5'd4,  2'b10, 32'h0000_00F0, 6, "op10");
        run_op(0, 32'hA5A5_0F0F, 5'd0,  2'b01, 32'hA5A5_0F0F, 6, "sh0");

        out_ready[0] = 1'b0;
        chk("bp_rdy", 32'(in_ready[0]), 32'd1);
        drive(0, 32'hF000_0000, 5'd4, 2'b11, 32'hFF00_0000);
        wait_result(0, 6, "bp_a");
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                in_valid[0] = 1'b1;
                in_data[0]  = 32'h0000_000F;
                in_shamt[0] = 5'd4;
                in_op[0]    = 2'b10;
            end
            @(negedge clk);
            chk("bp_hold_v", 32'(out_valid[0]), 32'd1);
            chk("bp_hold_d", out_data[0], 32'hFF00_0000);
            chk("bp_hold_r", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        exp_q.push_back(32'h0000_00F0);
        @(negedge clk);
        chk("bp_idle_r", 32'(in_ready[0]), 32'd1);
        chk("bp_idle_v", 32'(out_valid[0]), 32'd0);
        chk("bp_keep_d", out_data[0], 32'hFF00_0000);
        wait_result(0, 6, "bp_b");
        @(negedge clk);
        chk("bp_b_vdrop", 32'(out_valid[0]), 32'd0);

        drive(0, 32'h1234_5678, 5'd8, 2'b01, 32'h0012_3456);
        repeat (3) begin
            @(negedge clk);
            in_valid[0] = 1'b0;
        end
        chk("mid_busy", 32'(busy[0]), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid[0]), 32'd0);
        chk("mid_data", out_data[0], 32'd0);
        chk("mid_ready", 32'(in_ready[0]), 32'd1);
        chk("mid_busy0", 32'(busy[0]), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(0, 32'hFFFF_FFFF, 5'd4, 2'b01, 32'h0FFF_FFFF, 6, "post_rst");

        run_op(1, 32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1, "ee_sh0");
        run_op(1, 32'h1234_5678, 5'd16, 2'b01, 32'h0000_1234, 2, "ee_sh16");
        run_op(1, 32'h8000_0000, 5'd1,  2'b11, 32'hC000_0000, 6, "ee_sh1");
        run_op(1, 32'h0000_00AB, 5'd8,  2'b00, 32'h0000_AB00, 3, "ee_sh8");

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 2; j++) begin
                rd = $urandom;
                rs = 5'($urandom);
                ro = 2'($urandom);
                run_op(j, rd, rs, ro, ref_shift(rd, rs, ro),
                       ref_lat(j, rs), $sformatf("rnd%0d_%0d", j, i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iterative_shift_unit.md
Name: iterative_shift_unit

Overview:
- Multi-cycle 32-bit shifter for the ALU shift path; performs SLL, SRL and SRA.
- Applies one barrel stage per clock, in the order 16, 8, 4, 2, 1, gated by the corresponding shamt bit.
- Feeds the ALU result mux through a valid/ready handshake.
- Replaces the flat combinational 16/8/4/2/1 stage chain where timing requires a registered, iterative shifter.

Parameters:
- WIDTH, 32, data width; fixed at 32, not overridable.
- SHAMT_W, 5, shift-amount width (log2 WIDTH).
- EARLY_EXIT, 0:
  - 0 = always 5 stage cycles.
  - 1 = finish as soon as the remaining lower shamt bits are all zero.

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- in_data  input  32  operand
- in_shamt  input  5  shift amount 0..31
- in_op  input  2  operation select:
  - bit0: 1 = right, 0 = left.
  - bit1: 1 = arithmetic fill (right shifts only); ignored when bit0 = 0.
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  32  shifted result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset (asynchronous on reset_n low): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, internal regs cleared. Reset asserted mid-operation aborts with no result. Deassertion is taken synchronously at the next clock edge.
- States: IDLE, SHIFT, DONE.
- in_ready=1 only in IDLE, combinational from state. out_valid=1 only in DONE.
- IDLE:
  - On in_valid&in_ready, capture data, shamt, dir=op[0], arith=op[1]&op[0].
  - Set stage index k=4; go to SHIFT.
  - EARLY_EXIT=1 with shamt==0: go directly to DONE with acc=in_data.
- SHIFT, each cycle:
  - If shamt[k]=1, acc <= acc shifted by 2^k; otherwise acc is unchanged.
  - Fill for left and logical right = 0; fill for arithmetic right = acc[31] (sign of the current acc, which equals the original sign).
  - After k=0, go to DONE; otherwise k <= k-1.
  - EARLY_EXIT=1: if shamt[k-1:0]==0 after this stage, go to DONE now.
- Latency, EARLY_EXIT=0: capture edge + 5 stage edges. out_valid rises 6 cycles after the accept cycle, for every shamt including 0.
- Latency, EARLY_EXIT=1: accept cycle + (5 - index of lowest set shamt bit) stage cycles; shamt=0 completes in 1 cycle.
- DONE:
  - out_data=acc, held stable while out_valid&!out_ready.
  - On out_valid&out_ready, go to IDLE. out_data keeps its last value (not cleared). in_ready rises the following cycle; there is no same-cycle accept on the return to IDLE.
- in_valid while not ready: ignored. Producer must hold the request; no internal queue.
- Inputs are sampled only on the accept edge. Later changes to in_* do not affect an operation in flight.
- Stage index counter is 3 bits; never wraps below 0 (transition to DONE takes priority).

Decomposition:
- Package alu_shift_pkg:
  - OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11; 2'b10 behaves as SLL.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - WIDTH and SHAMT_W constants.
- Sub-module shift_stage_mux (combinational):
  - Inputs: acc, k, dir, fill bit, enable.
  - Output: acc shifted by 2^k (or passthrough).
  - Instantiated once; FSM/registers live in iterative_shift_unit.

Test Plan:
- SRL 0x80000000 by 16, EARLY_EXIT=0, out_ready=1 -> out_data=0x00008000, out_valid high exactly 6 cycles after accept for 1 cycle.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRA 0x7FFFFFFF by 31 -> 0x00000000.
- SLL 0x00000001 by 31 -> 0x80000000. op=2'b10, 0x0000000F by 4 -> 0x000000F0.
- Backpressure:
  - out_ready=0 for 10 cycles after DONE: out_valid and out_data stay stable, in_ready stays 0, a new in_valid is ignored.
  - Then out_ready=1: IDLE, and the next request is accepted one cycle later.
- EARLY_EXIT=1:
  - shamt=0 -> result = input, 1 cycle after accept.
  - shamt=16 -> 0x12345678 SRL gives 0x00001234 after 1 stage cycle.
  - shamt=1 takes 5 stage cycles.
- Reset mid-SHIFT: pull reset_n low after 2 stage cycles -> out_valid=0, out_data=0, in_ready=1 immediately (asynchronous). After release, a fresh SRL of 0xFFFFFFFF by 4 -> 0x0FFFFFFF.
